// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1: N-to-1 valid/ready channel mux with registered output, fixed-select or round-robin grant.
module mux_rr_nx1 #(
  parameter int WIDTH = 8,
  parameter int N = 4,
  parameter int SELW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);
  logic [SELW-1:0]  ptr, rr_gnt, gnt;
  logic [N-1:0]     hi;
  logic             rr_vld, fx_vld, gnt_vld, load_en, xfer;
  logic [WIDTH-1:0] gnt_data;
  assign load_en = ~out_valid | out_ready;
  // Channels at or above ptr take priority; otherwise wrap to the lowest valid channel.
  always_comb begin
    hi = '0;
    rr_gnt = '0;
    rr_vld = |in_valid;
    fx_vld = 1'b0;
    for (int k = 0; k < N; k++) hi[k] = in_valid[k] && (k >= int'(ptr));
    for (int k = N-1; k >= 0; k--) if (in_valid[k]) rr_gnt = SELW'(k);
    for (int k = N-1; k >= 0; k--) if (hi[k]) rr_gnt = SELW'(k);
    for (int k = 0; k < N; k++) if (int'(sel) == k && in_valid[k]) fx_vld = 1'b1;
  end
  assign gnt = mode ? rr_gnt : sel;
  assign gnt_vld = mode ? rr_vld : fx_vld;
  assign xfer = load_en & gnt_vld;
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N; k++) if (int'(gnt) == k) gnt_data = in_data[k*WIDTH +: WIDTH];
  end
  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign in_ready[i] = xfer & (int'(gnt) == i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= '0;
    end else if (xfer) begin
      out_data <= gnt_data;
      out_ch <= gnt;
      out_valid <= 1'b1;
      if (mode) ptr <= (int'(gnt) == N-1) ? '0 : gnt + 1'b1;
    end else if (load_en) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_rr_nx1.sv
// tb_mux_rr_nx1: scoreboard bench; a reference grant model predicts in_ready and the words that must emerge.
module tb_mux_rr_nx1;
  logic        clk = 0, rst, mode, out_ready, out_valid;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [2:0]  sel, out_ch;
  logic [7:0]  out_data;
  logic [7:0]  dv [4];
  logic [10:0] q [$];
  logic [2:0]  m_ptr;
  logic        m_ov;
  int          n_vec = 0, n_err = 0;
  mux_rr_nx1 #(.WIDTH(8), .N(4), .SELW(3)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = dv[i];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic peek_rdy(input string tag, input logic [3:0] exp);
    #1 chk(tag, {28'd0, in_ready}, {28'd0, exp});
  endtask
  task automatic cyc(input int n);
    logic [2:0] eg;
    logic       ev, ld;
    logic [10:0] w;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      ld = !m_ov || out_ready;
      ev = 0;
      eg = 0;
      if (!mode) begin
        eg = sel;
        ev = (sel < 4) && in_valid[sel[1:0]];
      end else
        for (int k = 3; k >= 0; k--)
          if (in_valid[(int'(m_ptr) + k) % 4]) begin
            ev = 1;
            eg = 3'((int'(m_ptr) + k) % 4);
          end
      chk("in_ready", {28'd0, in_ready}, (ld && ev) ? 32'd1 << eg : 32'd0);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      if (m_ov) begin
        if (q.size() == 0) chk("scoreboard_empty", 32'd0, 32'd1);
        else begin
          w = q[0];
          chk("out_data", {24'd0, out_data}, {24'd0, w[7:0]});
          chk("out_ch", {29'd0, out_ch}, {29'd0, w[10:8]});
          if (out_ready) void'(q.pop_front());
        end
      end
      if (ld && ev) begin
        q.push_back({eg, dv[eg[1:0]]});
        if (mode) m_ptr = (eg == 3) ? 3'd0 : eg + 3'd1;
      end
      if (ld) m_ov = ev;
      @(posedge clk);
      #1;
      if (ld && ev) dv[eg[1:0]] = dv[eg[1:0]] + 8'd1;
    end
  endtask
  initial begin
    rst = 1; mode = 0; sel = 0; in_valid = 0; out_ready = 1;
    m_ptr = 0; m_ov = 0;
    for (int i = 0; i < 4; i++) dv[i] = 8'h10 * 8'(i + 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_ch", {29'd0, out_ch}, 32'd0);
    rst = 0;
    // Fairness: all channels valid, consumer always ready.
    mode = 1; in_valid = 4'b1111;
    peek_rdy("rr_first", 4'b0001);
    cyc(7);
    // Async reset while a word is held.
    #1 rst = 1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", {24'd0, out_data}, 32'd0);
    chk("arst_out_ch", {29'd0, out_ch}, 32'd0);
    q.delete(); m_ov = 0; m_ptr = 0;
    @(posedge clk);
    #1 rst = 0;
    peek_rdy("rr_after_rst", 4'b0001);
    cyc(2);
    // Sparse round-robin starting from ptr=2.
    in_valid = 4'b0010;
    cyc(3);
    in_valid = 4'b1010;
    peek_rdy("sparse_first", 4'b1000);
    cyc(3);
    // Back-pressure then release.
    out_ready = 0;
    cyc(1);
    peek_rdy("bp_rdy", 4'b0000);
    cyc(5);
    out_ready = 1;
    cyc(3);
    // Mode switch preserves ptr.
    in_valid = 4'b0010;
    cyc(1);
    mode = 0; sel = 0; in_valid = 4'b1111;
    peek_rdy("fix_sel0", 4'b0001);
    cyc(3);
    mode = 1;
    peek_rdy("switch_back", 4'b0100);
    cyc(2);
    // Fixed select and out-of-range select.
    for (int i = 0; i < 4; i++) dv[i] = 8'hA0 + 8'(i);
    mode = 0; sel = 2;
    peek_rdy("fix_sel2", 4'b0100);
    cyc(3);
    sel = 3'd5;
    peek_rdy("sel_oob", 4'b0000);
    cyc(3);
    chk("drained", {31'd0, out_valid}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
